// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// One operation in flight; ties are broken round-robin on the last served requester.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  output logic                     rsp0_valid,
  input  logic                     rsp0_ready,
  output logic [DATA_WIDTH-1:0]    rsp0_data,
  output logic                     rsp1_valid,
  input  logic                     rsp1_ready,
  output logic [DATA_WIDTH-1:0]    rsp1_data,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state_reg, state_next;
  logic                     last_grant_reg;
  logic                     grant_id_reg;
  logic [OPCODE_LENGTH-1:0] op_reg;
  logic [DATA_WIDTH-1:0]    a_reg, b_reg, result_reg;

  logic grant_sel;
  logic idle_open;
  logic in_resp;
  logic accept;
  logic rsp_done;

  // On a tie the requester not served last wins; otherwise whoever is valid.
  always_comb begin
    grant_sel = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant_reg;
    end else if (req1_valid) begin
      grant_sel = 1'b1;
    end
  end

  // Reset masks every handshake output so nothing can complete in a reset cycle.
  assign idle_open  = (state_reg == IDLE) && !reset;
  assign req0_ready = idle_open && req0_valid && !grant_sel;
  assign req1_ready = idle_open && req1_valid && grant_sel;
  assign accept     = req0_ready || req1_ready;

  assign in_resp    = (state_reg == RESP) && !reset;
  assign rsp0_valid = in_resp && !grant_id_reg;
  assign rsp1_valid = in_resp && grant_id_reg;
  assign rsp0_data  = rsp0_valid ? result_reg : '0;
  assign rsp1_data  = rsp1_valid ? result_reg : '0;
  assign rsp_done   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign alu_op   = op_reg;
  assign alu_srca = a_reg;
  assign alu_srcb = b_reg;
  assign busy     = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_id_reg   <= 1'b0;
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      result_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        grant_id_reg <= grant_sel;
        op_reg       <= grant_sel ? req1_op : req0_op;
        a_reg        <= grant_sel ? req1_a  : req0_a;
        b_reg        <= grant_sel ? req1_b  : req0_b;
      end
      if (state_reg == EXEC) begin
        result_reg <= alu_result;
      end
      if (state_reg == RESP && rsp_done) begin
        last_grant_reg <= grant_id_reg;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single-requester operations
// plus hand sequences for ties, alternation, response stalls, reset abort.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data, alu_srca, alu_srcb, alu_result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy)
  );

  // Shared ALU model; codes outside this list return 0.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca | alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0011: alu_result = alu_srca ^ alu_srcb;
      4'b0100: alu_result = alu_srca << alu_srcb[4:0];
      4'b0101: alu_result = alu_srca >> alu_srcb[4:0];
      4'b0110: alu_result = alu_srca - alu_srcb;
      4'b0111: alu_result = $unsigned($signed(alu_srca) >>> alu_srcb[4:0]);
      4'b1100: alu_result = {31'd0, $signed(alu_srca) < $signed(alu_srcb)};
      4'b1101: alu_result = {31'd0, alu_srca < alu_srcb};
      default: alu_result = 32'd0;
    endcase
  end

  typedef struct {
    int          ch;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int ch, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
    if (ch == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = v;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = v;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered in an IDLE cycle after the negedge with requester inputs already driven.
  task automatic serve(input int ch, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int hold,
                       input bit drop, input string tag);
    logic me_rdy, ot_rdy, me_v, ot_v;
    logic [31:0] me_d, ot_d;
    #1;
    me_rdy = (ch == 0) ? req0_ready : req1_ready;
    ot_rdy = (ch == 0) ? req1_ready : req0_ready;
    chk({tag, "_ready"}, {31'd0, me_rdy}, 32'd1);
    chk({tag, "_other_ready"}, {31'd0, ot_rdy}, 32'd0);
    @(negedge clk);
    if (drop) begin
      if (ch == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end
    #1;
    chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_alu_op"}, {28'd0, alu_op}, {28'd0, op});
    chk({tag, "_alu_srca"}, alu_srca, a);
    chk({tag, "_alu_srcb"}, alu_srcb, b);
    chk({tag, "_exec_readys"}, {31'd0, req0_ready | req1_ready}, 32'd0);
    chk({tag, "_exec_rspv"}, {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    @(negedge clk);
    for (int h = 0; h <= hold; h++) begin
      #1;
      me_v = (ch == 0) ? rsp0_valid : rsp1_valid;
      ot_v = (ch == 0) ? rsp1_valid : rsp0_valid;
      me_d = (ch == 0) ? rsp0_data  : rsp1_data;
      ot_d = (ch == 0) ? rsp1_data  : rsp0_data;
      chk({tag, "_rsp_valid"}, {31'd0, me_v}, 32'd1);
      chk({tag, "_rsp_data"}, me_d, exp);
      chk({tag, "_other_rsp_valid"}, {31'd0, ot_v}, 32'd0);
      chk({tag, "_other_rsp_data"}, ot_d, 32'd0);
      chk({tag, "_resp_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_resp_readys"}, {31'd0, req0_ready | req1_ready}, 32'd0);
      if (h == hold) begin
        if (ch == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      end
      @(negedge clk);
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_rspv"}, {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    $display("txn %s ch%0d op=%h a=%h b=%h exp=%h got=%h", tag, ch, op, a, b, exp, me_d);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{0, 4'b0010, 32'd5,         32'd7, 32'd12};
    vecs[1] = '{1, 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1};
    vecs[2] = '{0, 4'b0100, 32'd1,         32'd4, 32'd16};
    vecs[3] = '{1, 4'b1111, 32'd3,         32'd4, 32'd0};
    vecs[4] = '{0, 4'b0110, 32'd100,       32'd1, 32'd99};
    vecs[5] = '{1, 4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000};
    vecs[6] = '{0, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000};

    reset = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set_req(0, 4'b0010, 32'd1, 32'd1, 1'b1);
    set_req(1, 4'b0010, 32'd2, 32'd2, 1'b1);

    // Reset state, with both valids high to show reset dominates
    @(negedge clk);
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rspv", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_alu_srca", alu_srca, 32'd0);
    chk("rst_alu_srcb", alu_srcb, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;

    // Stray rsp_ready while idle
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_rsprdy_busy", {31'd0, busy}, 32'd0);
      chk("idle_rsprdy_rspv", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
      chk("idle_rsprdy_data", rsp0_data | rsp1_data, 32'd0);
      chk("idle_rsprdy_readys", {31'd0, req0_ready | req1_ready}, 32'd0);
      chk("idle_rsprdy_alu", alu_srca | alu_srcb | {28'd0, alu_op}, 32'd0);
    end
    rsp0_ready = 1'b0;

    // Table of single-requester operations
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_req(vecs[i].ch, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      serve(vecs[i].ch, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, 1'b1,
            $sformatf("vec%0d", i));
    end

    // Tie from reset: requester 0 first, then requester 1
    do_reset();
    set_req(0, 4'b0011, 32'hF0, 32'h0F, 1'b1);
    set_req(1, 4'b0110, 32'd10, 32'd3, 1'b1);
    serve(0, 4'b0011, 32'hF0, 32'h0F, 32'hFF, 0, 1'b1, "tie_r0");
    serve(1, 4'b0110, 32'd10, 32'd3, 32'd7, 0, 1'b1, "tie_r1");

    // Continuous contention: grants alternate 0,1,0,1
    do_reset();
    set_req(0, 4'b0010, 32'd1, 32'd2, 1'b1);
    set_req(1, 4'b0110, 32'd9, 32'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        serve(0, 4'b0010, 32'd1, 32'd2, 32'd3, 0, 1'b0, $sformatf("rr%0d", k));
      else
        serve(1, 4'b0110, 32'd9, 32'd4, 32'd5, 0, 1'b0, $sformatf("rr%0d", k));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset during EXEC aborts the operation
    do_reset();
    set_req(0, 4'b0100, 32'd1, 32'd4, 1'b1);
    #1;
    chk("abort_accept", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_exec_busy", {31'd0, busy}, 32'd1);
    chk("abort_exec_op", {28'd0, alu_op}, 32'd4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_alu_op", {28'd0, alu_op}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_rsp", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
      @(negedge clk);
      #1;
    end
    $display("txn abort ch0 op=4 a=1 b=4 discarded");

    // Tie after abort: requester 0 still wins
    set_req(0, 4'b0100, 32'd1, 32'd4, 1'b1);
    set_req(1, 4'b1100, 32'hFFFF_FFFF, 32'd1, 1'b1);
    serve(0, 4'b0100, 32'd1, 32'd4, 32'd16, 0, 1'b1, "post_abort");

    // Requester 1 wins the next tie and stalls its response 3 cycles
    set_req(0, 4'b0010, 32'd5, 32'd7, 1'b1);
    serve(1, 4'b1100, 32'hFFFF_FFFF, 32'd1, 32'd1, 3, 1'b1, "stall_r1");
    serve(0, 4'b0010, 32'd5, 32'd7, 32'd12, 0, 1'b1, "after_stall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: DATA_WIDTH, 32, operand/result width.
- REQ-002: OPCODE_LENGTH, 4, ALU operation code width (same encoding as the shared ALU).
- REQ-003: clk  input  1  sole clock; all state updates on rising edge.
- REQ-004: reset  input  1  synchronous, active-high reset.
- REQ-005: req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
- REQ-006: req0_ready / req1_ready  output  1  arbiter accepts requester's operation this cycle.
- REQ-007: req0_op / req1_op  input  OPCODE_LENGTH  ALU operation code.
- REQ-008: req0_a, req0_b / req1_a, req1_b  input  DATA_WIDTH  operands A and B.
- REQ-009: rsp0_valid / rsp1_valid  output  1  result available for requester 0/1.
- REQ-010: rsp0_ready / rsp1_ready  input  1  requester 0/1 takes result.
- REQ-011: rsp0_data / rsp1_data  output  DATA_WIDTH  result value.
- REQ-012: alu_srca, alu_srcb  output  DATA_WIDTH  operands driven to the shared ALU.
- REQ-013: alu_op  output  OPCODE_LENGTH  operation driven to the shared ALU.
- REQ-014: alu_result  input  DATA_WIDTH  combinational ALU result.
- REQ-015: busy  output  1  high whenever state is not IDLE.

Function
- REQ-016: FSM states IDLE, EXEC, RESP; exactly one operation in flight.
- REQ-017: IDLE, no valid: stay IDLE, both ready low.
- REQ-018: IDLE, one valid: that requester granted.
- REQ-019: IDLE, both valid: round-robin; grant the requester NOT served last (last_grant pointer).
- REQ-020: reqN_ready = (state==IDLE) & grant==N; combinational from valids, never from rsp_ready; at most one ready high per cycle.
- REQ-021: On accept (valid&ready): register op, a, b and grant id; next state EXEC.
- REQ-022: alu_op/alu_srca/alu_srcb driven from the operand registers only (glitch-free, stable through EXEC).
- REQ-023: EXEC (one cycle): alu_result captured into result register; next state RESP.
- REQ-024: RESP: rspN_valid high only for granted requester; rspN_data = result register; other rsp_valid low, its data 0.
- REQ-025: RESP held, data stable, until rspN_ready; on handshake: last_grant <= N, next state IDLE.
- REQ-026: Latency: accept at cycle T -> rsp_valid first high at T+2; min issue interval 3 cycles.
- REQ-027: No new request accepted while busy; requesters hold valid and fields until ready.
- REQ-028: Opcode passed unmodified; all 16 codes legal; result is whatever the ALU returns (unused codes yield 0).
- REQ-029: rsp_ready asserted with no rsp_valid is ignored.

Reset
- REQ-030: reset forces state IDLE, last_grant=1 (requester 0 wins first tie), operand/op/result registers 0, all ready/valid outputs 0, busy 0.
- REQ-031: reset in EXEC or RESP aborts the operation: no response issued, no grant pointer update, result discarded.
- REQ-032: reset dominates all handshakes in the same cycle.

Verification
- REQ-033: After reset, req0 ADD(op 0010) a=5 b=7 -> req0_ready same cycle, rsp0_valid at T+2 with rsp0_data=12.
- REQ-034: Both requesters valid from reset (req0 XOR 0xF0^0x0F, req1 SUB 10-3) -> rsp0=0xFF first, then req1 granted in next IDLE, rsp1=7.
- REQ-035: Both valid continuously for 4 ops -> grants alternate 0,1,0,1; never two readys in one cycle.
- REQ-036: req1 signed less-than(op 1100) a=0xFFFFFFFF b=1 with rsp1_ready low 3 cycles -> rsp1_valid and rsp1_data=1 held stable, req0_ready stays low, busy=1, handshake on 4th cycle returns to IDLE.
- REQ-037: reset pulsed in EXEC of req0 shift-left(op 0100) a=1 b=4 -> no rsp0_valid ever for it; next tie grants req0 (last_grant=1).
- REQ-038: rsp0_ready high while idle, req valids low -> no state change, all outputs stay 0.
